pmem_responder: RTL and testbench

- Synthesizable physical-memory responder: the slave end of the cache's 128-bit line interface (pmem_read / pmem_write / pmem_resp).
- Accepts one line read or line write at a time, waits a programmable latency, then returns pmem_resp with read data, or commits write data.
- Serves as the memory side for cache fill/writeback paths in simulation and FPGA bring-up; replaces the behavioural memory model.

---
 rtl/pmem_responder.sv | 117 +++++++++++
 tb/tb_pmem_responder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pmem_responder.sv
// Physical-memory responder for the cache's 128-bit line port: one line read or
// write at a time, completed after a fixed LATENCY with a one-cycle pmem_resp.
module pmem_responder #(
    parameter int LATENCY    = 4,
    parameter int INDEX_BITS = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         pmem_read,
    input  logic         pmem_write,
    input  logic [15:0]  pmem_address,
    input  logic [127:0] pmem_wdata,
    output logic         pmem_resp,
    output logic [127:0] pmem_rdata,
    output logic         pmem_error,
    output logic [15:0]  read_count,
    output logic [15:0]  write_count
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam int         DEPTH  = 1 << INDEX_BITS;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [INDEX_BITS-1:0]   idx_q, idx_d;
    logic [127:0]            wdata_q, wdata_d;
    logic                    op_wr_q, op_wr_d;
    logic                    resp_q, resp_d;
    logic [127:0]            rdata_q, rdata_d;
    logic                    error_q, error_d;
    logic [15:0]             rd_cnt_q, rd_cnt_d;
    logic [15:0]             wr_cnt_q, wr_cnt_d;
    logic [127:0]            mem_q [DEPTH];
    logic                    mem_we;

    // Offset bits and upper address bits are intentionally don't-care (aliasing).
    logic unused_addr;
    assign unused_addr = ^{pmem_address[3:0], pmem_address[15:4+INDEX_BITS]};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        wdata_d  = wdata_q;
        op_wr_d  = op_wr_q;
        resp_d   = resp_q;
        rdata_d  = rdata_q;
        error_d  = error_q;
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        mem_we   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pmem_read || pmem_write) begin
                    idx_d   = pmem_address[4 +: INDEX_BITS];
                    wdata_d = pmem_wdata;
                    op_wr_d = pmem_write;
                    if (pmem_read && pmem_write) error_d = 1'b1;
                    cnt_d   = LAT_M1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    resp_d  = 1'b1;
                    if (op_wr_q) mem_we = 1'b1;
                    else         rdata_d = mem_q[idx_q];
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                resp_d  = 1'b0;
                state_d = IDLE;
                if (op_wr_q) wr_cnt_d = wr_cnt_q + 16'd1;
                else         rd_cnt_d = rd_cnt_q + 16'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            wdata_q  <= '0;
            op_wr_q  <= 1'b0;
            resp_q   <= 1'b0;
            rdata_q  <= '0;
            error_q  <= 1'b0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            wdata_q  <= wdata_d;
            op_wr_q  <= op_wr_d;
            resp_q   <= resp_d;
            rdata_q  <= rdata_d;
            error_q  <= error_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
            if (mem_we) mem_q[idx_q] <= wdata_q;
        end
    end

    assign pmem_resp   = resp_q;
    assign pmem_rdata  = rdata_q;
    assign pmem_error  = error_q;
    assign read_count  = rd_cnt_q;
    assign write_count = wr_cnt_q;
endmodule

// File: tb/tb_pmem_responder.sv
// Scoreboard bench for pmem_responder: a LATENCY=4 instance for the main
// function and a LATENCY=1 instance for minimum latency and counter wrap.
module tb_pmem_responder;
    localparam int LAT = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         rd, wr, rd1;
    logic [15:0]  addr, addr1;
    logic [127:0] wd;
    logic         resp, err, resp1, err1;
    logic [127:0] rdata, rdata1;
    logic [15:0]  rcnt, wcnt, rcnt1, wcnt1;

    always #5 clk = ~clk;

    pmem_responder #(.LATENCY(LAT), .INDEX_BITS(6)) dut (
        .clk(clk), .reset(reset), .pmem_read(rd), .pmem_write(wr),
        .pmem_address(addr), .pmem_wdata(wd), .pmem_resp(resp),
        .pmem_rdata(rdata), .pmem_error(err), .read_count(rcnt), .write_count(wcnt));

    pmem_responder #(.LATENCY(1), .INDEX_BITS(6)) dut_l1 (
        .clk(clk), .reset(reset), .pmem_read(rd1), .pmem_write(1'b0),
        .pmem_address(addr1), .pmem_wdata(128'd0), .pmem_resp(resp1),
        .pmem_rdata(rdata1), .pmem_error(err1), .read_count(rcnt1), .write_count(wcnt1));

    int           n_chk = 0, n_fail = 0;
    logic [127:0] exp_mem [64];
    logic [127:0] exp_q [$];
    logic [127:0] last_rdata;
    logic [15:0]  exp_rd, exp_wr, exp_rd1;
    logic         exp_err;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic int idx_of(input logic [15:0] a);
        return int'(a[9:4]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) exp_mem[i] = '0;
        exp_q.delete();
        last_rdata = '0;
        exp_rd = 0; exp_wr = 0; exp_rd1 = 0; exp_err = 1'b0;
    endtask

    // One transaction on the LATENCY=4 instance. hold: keep the request up through
    // the resp cycle. perturb: change address and drop the request during WAIT.
    task automatic xact(input logic r, input logic w, input logic [15:0] a,
                        input logic [127:0] d, input bit hold, input bit perturb);
        int   edges;
        bit   got;
        logic [127:0] e;
        @(negedge clk);
        rd = r; wr = w; addr = a; wd = d;
        if (w) begin
            exp_mem[idx_of(a)] = d;
            exp_wr++;
            if (r) exp_err = 1'b1;
        end else begin
            exp_q.push_back(exp_mem[idx_of(a)]);
            exp_rd++;
        end
        @(posedge clk);
        edges = 0; got = 0;
        while (!got && edges < 40) begin
            @(negedge clk);
            if (perturb && edges == 0) begin
                addr = 16'h0200; rd = 1'b0; wr = 1'b0;
            end
            if (resp) got = 1;
            else begin
                @(posedge clk);
                edges++;
            end
        end
        chk("resp_seen", 128'(got), 128'(1));
        chk("latency", 128'(edges), 128'(LAT));
        if (!w) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rdata", rdata, e);
                last_rdata = e;
            end else chk("sb_underflow", 128'(exp_q.size()), 128'(1));
        end else begin
            chk("rdata_hold", rdata, last_rdata);
        end
        if (!hold) begin rd = 1'b0; wr = 1'b0; end
        @(posedge clk);
        @(negedge clk);
        chk("resp_width", 128'(resp), 128'(0));
        if (hold) begin
            rd = 1'b0; wr = 1'b0;
            @(posedge clk);
            @(negedge clk);
            chk("no_dup_resp", 128'(resp), 128'(0));
        end
        chk("read_count", 128'(rcnt), 128'(exp_rd));
        chk("write_count", 128'(wcnt), 128'(exp_wr));
        chk("error", 128'(err), 128'(exp_err));
    endtask

    task automatic l1_read(input logic [15:0] a);
        int edges;
        bit got;
        @(negedge clk);
        rd1 = 1'b1; addr1 = a;
        exp_rd1++;
        @(posedge clk);
        edges = 0; got = 0;
        while (!got && edges < 40) begin
            @(negedge clk);
            if (resp1) got = 1;
            else begin
                @(posedge clk);
                edges++;
            end
        end
        chk("l1_resp_seen", 128'(got), 128'(1));
        chk("l1_latency", 128'(edges), 128'(1));
        chk("l1_rdata", rdata1, 128'd0);
        rd1 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("l1_resp_width", 128'(resp1), 128'(0));
        chk("l1_read_count", 128'(rcnt1), 128'(exp_rd1));
    endtask

    localparam logic [127:0] DAT_W = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] DAT_A = 128'hAAAA_5555_0000_FFFF_1234_5678_9ABC_DEF0;
    localparam logic [127:0] DAT_B = 128'hB0B0_B1B1_B2B2_B3B3_B4B4_B5B5_B6B6_B7B7;
    localparam logic [127:0] DAT_C = 128'hCCCC_CCCC_0000_0001_DEAD_BEEF_CAFE_F00D;
    localparam logic [127:0] DAT_D = 128'hD00D_D11D_D22D_D33D_D44D_D55D_D66D_D77D;

    initial begin
        rd = 0; wr = 0; addr = 0; wd = 0; rd1 = 0; addr1 = 0;
        reset = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_resp", 128'(resp), 128'(0));
        chk("rst_rdata", rdata, 128'd0);
        chk("rst_error", 128'(err), 128'(0));
        chk("rst_rcnt", 128'(rcnt), 128'(0));
        chk("rst_wcnt", 128'(wcnt), 128'(0));
        reset = 1'b0;

        xact(1, 0, 16'h0120, 128'd0, 0, 0);          // fresh array reads zero
        xact(0, 1, 16'h0040, DAT_W, 0, 0);
        xact(1, 0, 16'h004E, 128'd0, 0, 0);          // offset bits ignored
        xact(0, 1, 16'h0010, DAT_A, 1, 0);           // request held through resp
        xact(1, 0, 16'h0410, 128'd0, 0, 0);          // aliases onto index 1
        xact(1, 1, 16'h0080, DAT_B, 0, 0);           // both high: write wins, error
        xact(1, 0, 16'h0080, 128'd0, 0, 0);
        xact(0, 1, 16'h0100, DAT_D, 0, 0);
        xact(0, 1, 16'h0200, DAT_C, 0, 0);
        xact(1, 0, 16'h0100, 128'd0, 0, 1);          // perturbed mid-WAIT

        // Reset during WAIT of a write: abandoned, line stays cleared.
        @(negedge clk);
        wr = 1'b1; addr = 16'h0300; wd = DAT_C;
        @(posedge clk);
        @(negedge clk);
        wr = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        #1;
        chk("rst_mid_resp", 128'(resp), 128'(0));
        chk("rst_mid_error", 128'(err), 128'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (LAT + 2) begin
            @(negedge clk);
            chk("rst_no_resp", 128'(resp), 128'(0));
        end
        chk("rst_wcnt2", 128'(wcnt), 128'(0));
        xact(1, 0, 16'h0300, 128'd0, 0, 0);
        xact(1, 0, 16'h0100, 128'd0, 0, 0);          // earlier writes wiped too

        // Minimum latency and read_count wrap on the LATENCY=1 instance.
        l1_read(16'h0020);
        @(negedge clk);
        dut_l1.rd_cnt_q = 16'hFFFF;
        exp_rd1 = 16'hFFFF;
        l1_read(16'h0030);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
